re_order: RTL and testbench

RE_ORDER -- requirements
Module: re_order

---
 rtl/re_order.sv | 191 +++++++++++++++++++
 tb/tb_re_order.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/re_order.sv
// Bit-reversed to natural order frame reorderer with a ping-pong pair of LENGTH-deep banks.
// Build option: define RE_ORDER_FFTSHIFT_EN to read each frame out with its two halves swapped.
module re_order #(
   parameter int WIDTH  = 19,
   parameter int LENGTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [2*WIDTH-1:0]   s_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [2*WIDTH-1:0]   m_data,
   output logic                 m_last
);

   // state       | meaning
   // ST_EMPTY    | bank holds no frame, may be written
   // ST_FILLING  | bank has received part of a frame
   // ST_FULL     | bank holds a complete frame, waiting to be read
   // ST_DRAINING | bank is being read out in natural order

   localparam int AW = $clog2(LENGTH);
   localparam int CW = AW + 1;
   localparam int DW = 2 * WIDTH;

   localparam logic [AW-1:0] C_LAST_ADDR = AW'(LENGTH - 1);
   localparam logic [CW-1:0] C_LEN       = CW'(LENGTH);
   localparam logic [CW-1:0] C_LAST_CNT  = CW'(LENGTH - 1);
`ifdef RE_ORDER_FFTSHIFT_EN
   localparam logic [AW-1:0] C_RD_XOR    = AW'(LENGTH / 2);
`else
   localparam logic [AW-1:0] C_RD_XOR    = '0;
`endif

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_FILLING  = 2'd1,
      ST_FULL     = 2'd2,
      ST_DRAINING = 2'd3
   } bank_st_t;

   bank_st_t         r_st0;
   bank_st_t         r_st1;
   bank_st_t         w_st0_nxt;
   bank_st_t         w_st1_nxt;
   bank_st_t         w_wr_st;
   bank_st_t         w_rd_st;

   logic             r_wr_bank;
   logic [AW-1:0]    r_wr_cnt;
   logic             r_rd_bank;
   logic [CW-1:0]    r_rd_cnt;

   logic             r_m_valid;
   logic             r_m_last;
   logic [DW-1:0]    r_m_data;

   logic [DW-1:0]    r_mem [0:2*LENGTH-1];

   logic             w_s_ready;
   logic             w_wr_en;
   logic             w_wr_last;
   logic             w_rd_hs;
   logic             w_rd_done;
   logic             w_rd_load;
   logic [AW-1:0]    w_rd_addr;
   logic [AW-1:0]    w_wr_addr;
   logic [DW-1:0]    w_rd_word;

   function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      r = '0;
      for (int i = 0; i < AW; i++) begin
         r[i] = a[AW-1-i];
      end
      return r;
   endfunction

   // A FULL bank may only start draining when it is next in fill order and
   // the other bank has finished its own drain.
   function automatic bank_st_t f_bank_nxt(
      input bank_st_t cur,
      input bank_st_t other,
      input logic     is_wr_bank,
      input logic     is_rd_bank,
      input logic     wr_en,
      input logic     wr_last,
      input logic     rd_done
   );
      bank_st_t nxt;
      nxt = cur;
      unique case (cur)
         ST_EMPTY:    if (is_wr_bank && wr_en)                      nxt = ST_FILLING;
         ST_FILLING:  if (is_wr_bank && wr_last)                    nxt = ST_FULL;
         ST_FULL:     if (is_rd_bank && (other != ST_DRAINING))     nxt = ST_DRAINING;
         ST_DRAINING: if (is_rd_bank && rd_done)                    nxt = ST_EMPTY;
         default:                                                   nxt = ST_EMPTY;
      endcase
      return nxt;
   endfunction

   assign w_wr_st   = r_wr_bank ? r_st1 : r_st0;
   assign w_rd_st   = r_rd_bank ? r_st1 : r_st0;

   assign w_s_ready = reset && ((w_wr_st == ST_EMPTY) || (w_wr_st == ST_FILLING));
   assign w_wr_en   = s_valid && w_s_ready;
   assign w_wr_last = w_wr_en && (r_wr_cnt == C_LAST_ADDR);
   assign w_wr_addr = f_bitrev(r_wr_cnt);

   assign w_rd_hs   = r_m_valid && m_ready;
   assign w_rd_done = w_rd_hs && r_m_last;
   // The output register is refilled whenever it is empty or being consumed.
   assign w_rd_load = (w_rd_st == ST_DRAINING) && (r_rd_cnt != C_LEN) &&
                      (!r_m_valid || m_ready);
   assign w_rd_addr = r_rd_cnt[AW-1:0] ^ C_RD_XOR;
   assign w_rd_word = r_mem[{r_rd_bank, w_rd_addr}];

   always_comb begin
      w_st0_nxt = r_st0;
      w_st1_nxt = r_st1;
      w_st0_nxt = f_bank_nxt(r_st0, r_st1, ~r_wr_bank, ~r_rd_bank,
                             w_wr_en, w_wr_last, w_rd_done);
      w_st1_nxt = f_bank_nxt(r_st1, r_st0,  r_wr_bank,  r_rd_bank,
                             w_wr_en, w_wr_last, w_rd_done);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st0 <= ST_EMPTY;
         r_st1 <= ST_EMPTY;
      end else begin
         r_st0 <= w_st0_nxt;
         r_st1 <= w_st1_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
      end else if (w_wr_en) begin
         r_wr_cnt <= r_wr_cnt + AW'(1);
         if (w_wr_last) begin
            r_wr_bank <= ~r_wr_bank;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_bank <= 1'b0;
         r_rd_cnt  <= '0;
      end else if (w_rd_done) begin
         r_rd_bank <= ~r_rd_bank;
         r_rd_cnt  <= '0;
      end else if (w_rd_load) begin
         r_rd_cnt  <= r_rd_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
         r_m_data  <= '0;
      end else if (w_rd_load) begin
         r_m_valid <= 1'b1;
         r_m_last  <= (r_rd_cnt == C_LAST_CNT);
         r_m_data  <= w_rd_word;
      end else if (w_rd_hs) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end
   end

   // Storage has no reset; stale contents are never read because the bank
   // states gate every access.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[{r_wr_bank, w_wr_addr}] <= s_data;
      end
   end

   assign s_ready = w_s_ready;
   assign m_valid = r_m_valid;
   assign m_last  = r_m_last;
   assign m_data  = r_m_data;

endmodule

// File: tb/tb_re_order.sv
// Directed bench for re_order: reset, ordering, latency, throughput, stalls, mid-frame reset, random traffic.
// Expected order follows RE_ORDER_FFTSHIFT_EN when that macro is defined for the build.
module tb_re_order;

   localparam int W  = 19;
   localparam int L  = 8;
   localparam int DW = 2 * W;
`ifdef RE_ORDER_FFTSHIFT_EN
   localparam int SH = L / 2;
`else
   localparam int SH = 0;
`endif

   logic          clk     = 1'b0;
   logic          reset   = 1'b0;
   logic          s_valid = 1'b0;
   logic          m_ready = 1'b0;
   logic [DW-1:0] s_data  = '0;
   logic          s_ready;
   logic          m_valid;
   logic          m_last;
   logic [DW-1:0] m_data;

   re_order #(.WIDTH(W), .LENGTH(L)) dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_acc = 0;
   int rise_cyc = 0;
   int n_out = 0;
   int n_last = 0;
   int n_pushed = 0;
   int low_run = 0;
   int max_low = 0;
   int frm_n = 0;
   logic          mv_prev = 1'b0;
   logic          stall_prev = 1'b0;
   logic [DW:0]   stall_word = '0;
   logic [DW:0]   exp_q[$];
   logic [DW-1:0] frm [L];
   logic [W-1:0]  out_log[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int br3(input int a);
      return ((a & 1) << 2) | (a & 2) | ((a >> 2) & 1);
   endfunction

   function automatic logic [DW-1:0] mk(input int re, input int im);
      return {W'(im), W'(re)};
   endfunction

   // One clock: drive at negedge, sample 1ns later, then score handshakes at posedge.
   task automatic tick(input logic sv, input logic [DW-1:0] sd, input logic mr, output logic acc);
      logic          in_hs;
      logic          out_hs;
      logic [DW-1:0] od;
      logic          ol;
      @(negedge clk);
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      #1;
      if (stall_prev) begin
         chk("stall_valid", m_valid, 1);
         chk("stall_word", {m_last, m_data}, stall_word);
      end
      if (m_valid && !mv_prev) rise_cyc = cyc;
      mv_prev    = m_valid;
      in_hs      = s_valid && s_ready;
      out_hs     = m_valid && m_ready;
      od         = m_data;
      ol         = m_last;
      stall_prev = m_valid && !m_ready;
      stall_word = {m_last, m_data};
      if (s_valid && !s_ready) begin
         low_run++;
         if (low_run > max_low) max_low = low_run;
      end else begin
         low_run = 0;
      end
      @(posedge clk);
      cyc++;
      acc = in_hs;
      if (in_hs) begin
         last_acc   = cyc;
         frm[frm_n] = sd;
         frm_n++;
         if (frm_n == L) begin
            for (int j = 0; j < L; j++) begin
               exp_q.push_back({(j == L - 1), frm[br3(j ^ SH)]});
               n_pushed++;
            end
            frm_n = 0;
         end
      end
      if (out_hs) begin
         n_out++;
         if (ol) n_last++;
         out_log.push_back(od[W-1:0]);
         if (exp_q.size() > 0) chk("out_word", {ol, od}, exp_q.pop_front());
         else                  chk("out_extra", n_out, n_pushed);
      end
   endtask

   task automatic send(input logic [DW-1:0] sd, input logic mr);
      logic acc;
      int   g;
      acc = 1'b0;
      g   = 0;
      while (!acc && g < 500) begin
         tick(1'b1, sd, mr, acc);
         g++;
      end
      chk("send_accept", acc, 1);
   endtask

   task automatic drain(input int budget);
      logic acc;
      int   i;
      i = 0;
      while (exp_q.size() > 0 && i < budget) begin
         tick(1'b0, '0, 1'b1, acc);
         i++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      int t1 [L];
      int out0;
      int last0;
      int cnt;
      int guard;
      logic acc;
      logic [DW-1:0] word;

      t1 = '{0, 4, 2, 6, 1, 5, 3, 7};

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      reset = 1'b1;
      #1;
      chk("rel_s_ready", s_ready, 1);

      // bit-reversed frame -> natural order, latency
      out_log.delete();
      out0  = n_out;
      last0 = n_last;
      for (int i = 0; i < L; i++) send(mk(t1[i], 0), 1'b1);
      drain(50);
      chk("t1_latency", rise_cyc - last_acc, 2);
      chk("t1_count", n_out - out0, L);
      chk("t1_lasts", n_last - last0, 1);
      for (int k = 0; k < L; k++) begin
         if (k < out_log.size()) chk("t1_order", out_log[k], k ^ SH);
      end

      // three back-to-back frames at full rate
      out0    = n_out;
      last0   = n_last;
      max_low = 0;
      low_run = 0;
      for (int i = 0; i < 3 * L; i++) send(mk(i, i + 1000), 1'b1);
      drain(100);
      chk("t2_sready_low_le2", (max_low <= 2), 1);
      chk("t2_count", n_out - out0, 3 * L);
      chk("t2_lasts", n_last - last0, 3);

      // downstream stalled while three frames are offered
      out0  = n_out;
      last0 = n_last;
      cnt   = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1'b1, mk(cnt + 200, cnt), 1'b0, acc);
         if (acc) cnt++;
      end
      #1;
      chk("t3_accepts", cnt, 2 * L);
      chk("t3_s_ready", s_ready, 0);
      chk("t3_m_valid", m_valid, 1);
      while (cnt < 3 * L) begin
         send(mk(cnt + 200, cnt), 1'b1);
         cnt++;
      end
      drain(100);
      chk("t3_count", n_out - out0, 3 * L);
      chk("t3_lasts", n_last - last0, 3);

      // reset in the middle of a frame
      for (int i = 0; i < 5; i++) send(mk(500 + i, 7), 1'b1);
      @(negedge clk);
      reset   = 1'b0;
      s_valid = 1'b0;
      #1;
      chk("t4_rst_s_ready", s_ready, 0);
      chk("t4_rst_m_valid", m_valid, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("t4_rst2_s_ready", s_ready, 0);
      chk("t4_rst2_m_valid", m_valid, 0);
      chk("t4_rst2_m_last", m_last, 0);
      frm_n      = 0;
      exp_q.delete();
      stall_prev = 1'b0;
      mv_prev    = 1'b0;
      reset      = 1'b1;
      out0       = n_out;
      out_log.delete();
      for (int i = 0; i < L; i++) send(mk(600 + br3(i), 9), 1'b1);
      drain(50);
      chk("t4_count", n_out - out0, L);
      for (int k = 0; k < L; k++) begin
         if (k < out_log.size()) chk("t4_order", out_log[k], 600 + (k ^ SH));
      end

      // random valid/ready over 100 frames
      out0  = n_out;
      last0 = n_last;
      cnt   = 0;
      guard = 0;
      word  = mk($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1));
      while (cnt < 100 * L && guard < 20000) begin
         tick(1'($urandom_range(0, 1)), word, 1'($urandom_range(0, 1)), acc);
         if (acc) begin
            cnt++;
            word = mk($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1));
         end
         guard++;
      end
      chk("t5_accepts", cnt, 100 * L);
      drain(200);
      chk("t5_count", n_out - out0, 100 * L);
      chk("t5_lasts", n_last - last0, 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
